// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC into a synchronous instruction
// memory, captures the returned word one cycle later and queues it, tagged
// with its PC, in a two-entry buffer toward decode (valid/ready handshake).
// A redirect reloads the PC and discards both the queue and the read still
// in flight.
module fetch_unit #(
  parameter int instruct_size = 4,
  parameter int num_instructs = 512,
  parameter int addr_width    = $clog2(num_instructs),
  parameter int reset_pc      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [addr_width-1:0]    imem_addr,
  input  logic [instruct_size-1:0] imem_data,
  input  logic                     redirect_valid,
  input  logic [addr_width-1:0]    redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [instruct_size-1:0] out_instr,
  output logic [addr_width-1:0]    out_pc
);

  localparam logic [addr_width-1:0] LAST_PC  = addr_width'(num_instructs - 1);
  localparam logic [addr_width-1:0] RESET_PC = addr_width'(reset_pc);
  localparam logic [addr_width-1:0] PC_ONE   = addr_width'(1);

  // Sequential increment that wraps at the memory depth rather than at the
  // power of two; anything at or past the last word (an out-of-range redirect
  // target included) wraps to 0.
  function automatic logic [addr_width-1:0] wrap_inc(
    input logic [addr_width-1:0] p
  );
    if (p >= LAST_PC) begin
      return '0;
    end
    return p + PC_ONE;
  endfunction

  // Stage p0: PC presented to the memory this cycle.
  logic [addr_width-1:0]    pc_p0;
  // Stage p1: a read issued last cycle whose data is on imem_data now.
  logic                     vld_p1;
  logic [addr_width-1:0]    pc_p1;
  // Output queue: slot 0 is the head shown to decode, slot 1 the tail.
  logic [instruct_size-1:0] instr_q0;
  logic [instruct_size-1:0] instr_q1;
  logic [addr_width-1:0]    pc_q0;
  logic [addr_width-1:0]    pc_q1;
  logic [1:0]               count;

  logic                     pop;
  logic                     push;
  logic                     issue;
  logic [2:0]               occupancy;
  logic                     write_head;
  logic                     write_tail;
  logic                     shift;
  logic [addr_width-1:0]    pc_next;

  // Handshake, issue and queue-steering decisions for this cycle.
  always_comb begin
    out_valid  = (count != 2'd0);
    pop        = out_valid & out_ready;
    push       = vld_p1 & ~redirect_valid;
    // Entries that will be held or still owed once this cycle's pop retires;
    // a new read is only launched if its data is guaranteed a slot.
    occupancy  = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
    issue      = ~redirect_valid & (occupancy < 3'd2);
    // Incoming word lands in the head when the queue is (or becomes) empty,
    // otherwise in the tail; a pop from a full queue moves the tail forward.
    write_head = push & ((count == 2'd0) | (pop & (count == 2'd1)));
    write_tail = push & ~write_head;
    shift      = pop & (count == 2'd2);
    pc_next    = wrap_inc(pc_p0);
  end

  assign imem_addr = pc_p0;
  assign out_instr = out_valid ? instr_q0 : '0;
  assign out_pc    = out_valid ? pc_q0    : '0;

  // Control state: PC, in-flight flag and queue occupancy; reset, then
  // redirect, take precedence over normal issue/return traffic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_p0  <= RESET_PC;
      vld_p1 <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_valid) begin
      pc_p0  <= redirect_pc;
      vld_p1 <= 1'b0;
      count  <= 2'd0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        pc_p0 <= pc_next;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Datapath: in-flight PC tag and queue payload; contents only matter while
  // the matching control bits mark them valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_p1 <= pc_p0;
    end
    if (shift) begin
      instr_q0 <= instr_q1;
      pc_q0    <= pc_q1;
    end
    if (write_head) begin
      instr_q0 <= imem_data;
      pc_q0    <= pc_p1;
    end
    if (write_tail) begin
      instr_q1 <= imem_data;
      pc_q1    <= pc_p1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous memory model plus a queue-based
// reference of the fetch pipeline, directed scenarios and a random run.
module tb_fetch_unit;

  localparam int IS  = 4;
  localparam int NI  = 512;
  localparam int AW  = $clog2(NI);
  localparam int RPC = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [IS-1:0] imem_data;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [IS-1:0] out_instr;
  logic [AW-1:0] out_pc;

  int checks = 0;
  int errors = 0;

  logic [IS-1:0] mem [NI];

  typedef struct packed {
    logic [IS-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t mq[$];
  bit   m_inf = 1'b0;
  int   m_inf_pc = 0;
  int   m_pc = RPC;

  fetch_unit #(
    .instruct_size(IS),
    .num_instructs(NI),
    .addr_width   (AW),
    .reset_pc     (RPC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  // Synchronous memory: one-cycle read latency.
  always @(posedge clk) imem_data <= mem[imem_addr];

  function automatic int inc_pc(input int p);
    return (p + 1) % NI;
  endfunction

  // Expected {out_valid, out_pc, out_instr, imem_addr} from the reference.
  function automatic logic [1+AW+IS+AW-1:0] exp_vec();
    logic          v;
    logic [AW-1:0] p;
    logic [IS-1:0] d;
    v = (mq.size() != 0);
    p = v ? mq[0].pc : '0;
    d = v ? mq[0].instr : '0;
    return {v, p, d, AW'(m_pc)};
  endfunction

  // Drive one cycle of inputs, advance the reference across the edge.
  task automatic tick(input bit rn, input bit rv, input int rpc, input bit rdy);
    bit   pop;
    bit   iss;
    ent_t e;
    rst_n          = rn;
    redirect_valid = rv;
    redirect_pc    = AW'(rpc);
    out_ready      = rdy;
    @(posedge clk);
    pop = (mq.size() != 0) && rdy;
    if (!rn) begin
      mq.delete();
      m_inf = 1'b0;
      m_pc  = RPC;
    end else if (rv) begin
      mq.delete();
      m_inf = 1'b0;
      m_pc  = rpc;
    end else begin
      iss = (mq.size() + int'(m_inf) - int'(pop)) < 2;
      if (pop) void'(mq.pop_front());
      if (m_inf) begin
        e.instr = mem[m_inf_pc];
        e.pc    = AW'(m_inf_pc);
        mq.push_back(e);
      end
      m_inf = iss;
      if (iss) begin
        m_inf_pc = m_pc;
        m_pc     = inc_pc(m_pc);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 0, 1'b1);
    tick(1'b0, 1'b1, 9, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %0b want 0", out_valid);
    end
    checks++;
    if (out_pc !== '0 || out_instr !== '0) begin
      errors++;
      $display("FAIL reset_outs: got pc=%0h instr=%0h want 0/0", out_pc, out_instr);
    end
    checks++;
    if (imem_addr !== AW'(RPC)) begin
      errors++;
      $display("FAIL reset_addr: got %0h want %0h", imem_addr, RPC);
    end
  endtask

  task automatic test_stream();
    bit v;
    tick(1'b0, 1'b0, 0, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      tick(1'b1, 1'b0, 0, 1'b1);
      v = (i >= 2);
      checks++;
      if (out_valid !== v ||
          (v && (out_pc !== AW'(i - 2) || out_instr !== IS'((i - 2) % 16)))) begin
        errors++;
        $display("FAIL stream_c%0d: got v=%0b pc=%0h instr=%0h want v=%0b pc=%0h",
                 i, out_valid, out_pc, out_instr, v, i - 2);
      end
    end
  endtask

  task automatic test_backpressure();
    tick(1'b0, 1'b0, 0, 1'b1);
    for (int i = 1; i <= 5; i++) tick(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== AW'(3)) begin
      errors++;
      $display("FAIL bp_head: got v=%0b pc=%0h want 1/3", out_valid, out_pc);
    end
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, 0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== AW'(3) || out_instr !== IS'(3) ||
          imem_addr !== AW'(5)) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%0b pc=%0h instr=%0h addr=%0h want 1/3/3/5",
                 k, out_valid, out_pc, out_instr, imem_addr);
      end
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== AW'(3 + j) || out_instr !== IS'(3 + j)) begin
        errors++;
        $display("FAIL bp_release_%0d: got v=%0b pc=%0h instr=%0h want pc=%0h",
                 j, out_valid, out_pc, out_instr, 3 + j);
      end
      tick(1'b1, 1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_redirect();
    tick(1'b0, 1'b0, 0, 1'b1);
    for (int i = 1; i <= 8; i++) tick(1'b1, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b1, 'h1F0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== AW'('h1F0)) begin
      errors++;
      $display("FAIL redir_t1: got v=%0b addr=%0h want 0/1f0", out_valid, imem_addr);
    end
    tick(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_t2: got v=%0b want 0", out_valid);
    end
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, 1'b0, 0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== AW'('h1F0 + j) || out_instr !== IS'(j)) begin
        errors++;
        $display("FAIL redir_beat_%0d: got v=%0b pc=%0h instr=%0h want pc=%0h instr=%0h",
                 j, out_valid, out_pc, out_instr, 'h1F0 + j, j);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_pc [4];
    exp_pc = '{510, 511, 0, 1};
    tick(1'b0, 1'b0, 0, 1'b1);
    for (int i = 1; i <= 3; i++) tick(1'b1, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b1, 510, 1'b1);
    checks++;
    if (imem_addr !== AW'(510)) begin
      errors++;
      $display("FAIL wrap_addr0: got %0d want 510", imem_addr);
    end
    tick(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (imem_addr !== AW'(511)) begin
      errors++;
      $display("FAIL wrap_addr1: got %0d want 511", imem_addr);
    end
    tick(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (imem_addr !== AW'(0)) begin
      errors++;
      $display("FAIL wrap_addr2: got %0d want 0", imem_addr);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== AW'(exp_pc[j]) ||
          out_instr !== IS'(exp_pc[j] % 16)) begin
        errors++;
        $display("FAIL wrap_beat_%0d: got v=%0b pc=%0d instr=%0h want pc=%0d",
                 j, out_valid, out_pc, out_instr, exp_pc[j]);
      end
      tick(1'b1, 1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_redirect_pop();
    tick(1'b0, 1'b0, 0, 1'b1);
    for (int i = 1; i <= 9; i++) tick(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== AW'(7)) begin
      errors++;
      $display("FAIL rp_head: got v=%0b pc=%0h want 1/7", out_valid, out_pc);
    end
    tick(1'b1, 1'b1, 'h100, 1'b1);
    tick(1'b1, 1'b1, 'h40, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rp_gap_%0d: got v=%0b pc=%0h want 0", k, out_valid, out_pc);
      end
      tick(1'b1, 1'b0, 0, 1'b1);
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== AW'('h40 + j) || out_instr !== IS'(j)) begin
        errors++;
        $display("FAIL rp_beat_%0d: got v=%0b pc=%0h want pc=%0h",
                 j, out_valid, out_pc, 'h40 + j);
      end
      tick(1'b1, 1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b0, 0, 1'b1);
    for (int i = 1; i <= 4; i++) tick(1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== AW'(2) || imem_addr !== AW'(4)) begin
      errors++;
      $display("FAIL rm_full: got v=%0b pc=%0h addr=%0h want 1/2/4",
               out_valid, out_pc, imem_addr);
    end
    tick(1'b0, 1'b1, 'h55, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_pc !== '0 || out_instr !== '0 ||
        imem_addr !== AW'(RPC)) begin
      errors++;
      $display("FAIL rm_cleared: got v=%0b pc=%0h instr=%0h addr=%0h want 0/0/0/%0h",
               out_valid, out_pc, out_instr, imem_addr, RPC);
    end
    tick(1'b1, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b0, 0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== AW'(RPC)) begin
      errors++;
      $display("FAIL rm_restart: got v=%0b pc=%0h want 1/%0h", out_valid, out_pc, RPC);
    end
  endtask

  task automatic test_random();
    bit rn;
    bit rv;
    bit rdy;
    int rpc;
    logic [1+AW+IS+AW-1:0] want;
    tick(1'b0, 1'b0, 0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      rn  = ($urandom_range(0, 99) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, NI - 1))
                                        : int'($urandom_range(NI - 8, NI - 1));
      rdy = ($urandom_range(0, 3) != 0);
      tick(rn, rv, rpc, rdy);
      want = exp_vec();
      checks++;
      if ({out_valid, out_pc, out_instr, imem_addr} !== want) begin
        errors++;
        $display("FAIL random_%0d: got v=%0b pc=%0h instr=%0h addr=%0h want v=%0b pc=%0h instr=%0h addr=%0h",
                 n, out_valid, out_pc, out_instr, imem_addr,
                 want[1+AW+IS+AW-1], want[AW+IS+AW-1 -: AW], want[IS+AW-1 -: IS], want[AW-1:0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) mem[i] = IS'(i % 16);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_redirect_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
